// File: rtl/ibex_fpga_mem_pkg.sv
// rtl/ibex_fpga_mem_pkg.sv - shared types and constants for the Ibex FPGA memory arbiter
package ibex_fpga_mem_pkg;

    localparam int unsigned MemDepth      = 32768;
    localparam int unsigned AddrWidth     = $clog2(MemDepth);
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned StallCntWidth = 16;

    // Which requester owns an access; NONE marks an idle or write slot
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } port_e;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [DataWidth-1:0] strb_t;

    localparam logic [StallCntWidth-1:0] StallCntMax = '1;

endpackage

// File: rtl/ibex_fpga_sat_counter.sv
// rtl/ibex_fpga_sat_counter.sv - saturating up-counter used for stall statistics
module ibex_fpga_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {Width{1'b1}})) begin
            cnt_o <= cnt_o + Width'(1);
        end
    end

endmodule

// File: rtl/ibex_fpga_mem_arbiter.sv
// rtl/ibex_fpga_mem_arbiter.sv - round-robin merge of Ibex instr/data ports onto one BRAM port
module ibex_fpga_mem_arbiter
    import ibex_fpga_mem_pkg::*;
#(
    parameter  int unsigned MemDepth      = 32768,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned StallCntWidth = 16,
    localparam int unsigned AddrWidth     = $clog2(MemDepth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     instr_req_i,
    output logic                     instr_gnt_o,
    input  logic [AddrWidth-1:0]     instr_addr_i,
    input  logic [DataWidth-1:0]     instr_wdata_i,
    input  logic [DataWidth-1:0]     instr_strb_i,
    input  logic                     instr_we_i,
    output logic [DataWidth-1:0]     instr_rdata_o,

    input  logic                     data_req_i,
    output logic                     data_gnt_o,
    input  logic [AddrWidth-1:0]     data_addr_i,
    input  logic [DataWidth-1:0]     data_wdata_i,
    input  logic [DataWidth-1:0]     data_strb_i,
    input  logic                     data_we_i,
    output logic [DataWidth-1:0]     data_rdata_o,

    output logic                     mem_req_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth-1:0]     mem_strb_o,
    output logic                     mem_we_o,
    input  logic [DataWidth-1:0]     mem_rdata_i,

    output logic [StallCntWidth-1:0] instr_stall_cnt_o,
    output logic [StallCntWidth-1:0] data_stall_cnt_o
);

    port_e                last_winner_q;
    port_e                rd_owner_q;
    port_e                winner;
    logic                 conflict;
    logic [DataWidth-1:0] instr_hold_q;
    logic [DataWidth-1:0] data_hold_q;

    // Pick the winner: a lone requester always wins, a conflict goes to the port that lost last time
    always_comb begin
        winner   = NONE;
        conflict = instr_req_i & data_req_i;
        if (conflict) begin
            winner = (last_winner_q == DATA) ? INSTR : DATA;
        end else if (instr_req_i) begin
            winner = INSTR;
        end else if (data_req_i) begin
            winner = DATA;
        end
    end

    assign instr_gnt_o = (winner == INSTR);
    assign data_gnt_o  = (winner == DATA);

    // Steer the granted port onto the BRAM; strobes are forced low unless the access writes
    always_comb begin
        mem_req_o   = instr_req_i | data_req_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_we_o    = 1'b0;
        mem_strb_o  = '0;
        if (winner == INSTR) begin
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = instr_wdata_i;
            mem_we_o    = instr_we_i;
            mem_strb_o  = instr_we_i ? instr_strb_i : '0;
        end else if (winner == DATA) begin
            mem_we_o    = data_we_i;
            mem_strb_o  = data_we_i ? data_strb_i : '0;
        end
    end

    // Returning read data bypasses to its owner in the return cycle; otherwise the hold register shows
    assign instr_rdata_o = (rd_owner_q == INSTR) ? mem_rdata_i : instr_hold_q;
    assign data_rdata_o  = (rd_owner_q == DATA)  ? mem_rdata_i : data_hold_q;

    // Round-robin history, read ownership for the next cycle, and per-port read data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_winner_q <= DATA;
            rd_owner_q    <= NONE;
            instr_hold_q  <= '0;
            data_hold_q   <= '0;
        end else begin
            if (conflict) begin
                last_winner_q <= winner;
            end
            rd_owner_q <= ((winner != NONE) && !mem_we_o) ? winner : NONE;
            if (rd_owner_q == INSTR) begin
                instr_hold_q <= mem_rdata_i;
            end
            if (rd_owner_q == DATA) begin
                data_hold_q <= mem_rdata_i;
            end
        end
    end

    ibex_fpga_sat_counter #(
        .Width (StallCntWidth)
    ) u_instr_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (instr_req_i & ~instr_gnt_o),
        .cnt_o  (instr_stall_cnt_o)
    );

    ibex_fpga_sat_counter #(
        .Width (StallCntWidth)
    ) u_data_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (data_req_i & ~data_gnt_o),
        .cnt_o  (data_stall_cnt_o)
    );

endmodule

// File: tb/tb_ibex_fpga_mem_arbiter.sv
// tb/tb_ibex_fpga_mem_arbiter.sv - self-checking bench for the Ibex FPGA memory arbiter
module tb_ibex_fpga_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_we_i;
    logic [14:0] instr_addr_i;
    logic [31:0] instr_wdata_i, instr_strb_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [14:0] data_addr_i;
    logic [31:0] data_wdata_i, data_strb_i, data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [14:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_strb_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic [15:0] instr_stall_cnt_o, data_stall_cnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    bit          m_last_was_data;
    int          m_owner;          // 0 none, 1 instr, 2 data
    logic [31:0] m_pend, m_hold_i, m_hold_d;
    int          m_cnt_i, m_cnt_d;
    logic        last_gi, last_gd;
    logic [31:0] last_strb;
    logic        last_we;

    logic [31:0] bram [0:32767];

    ibex_fpga_mem_arbiter dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .instr_req_i       (instr_req_i),
        .instr_gnt_o       (instr_gnt_o),
        .instr_addr_i      (instr_addr_i),
        .instr_wdata_i     (instr_wdata_i),
        .instr_strb_i      (instr_strb_i),
        .instr_we_i        (instr_we_i),
        .instr_rdata_o     (instr_rdata_o),
        .data_req_i        (data_req_i),
        .data_gnt_o        (data_gnt_o),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .data_strb_i       (data_strb_i),
        .data_we_i         (data_we_i),
        .data_rdata_o      (data_rdata_o),
        .mem_req_o         (mem_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_strb_o        (mem_strb_o),
        .mem_we_o          (mem_we_o),
        .mem_rdata_i       (mem_rdata_i),
        .instr_stall_cnt_o (instr_stall_cnt_o),
        .data_stall_cnt_o  (data_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // BRAM with one-cycle read latency; read data is garbage outside return cycles
    always @(posedge clk_i) begin
        if (mem_req_o && mem_we_o) begin
            bram[mem_addr_o] <= (bram[mem_addr_o] & ~mem_strb_o) | (mem_wdata_o & mem_strb_o);
            mem_rdata_i      <= $urandom;
        end else if (mem_req_o) begin
            mem_rdata_i <= bram[mem_addr_o];
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_was_data = 1'b1;
        m_owner  = 0;
        m_pend   = 32'h0;
        m_hold_i = 32'h0;
        m_hold_d = 32'h0;
        m_cnt_i  = 0;
        m_cnt_d  = 0;
        last_gi  = 1'b0;
        last_gd  = 1'b0;
    endtask

    task automatic drive(input logic ir, input logic [14:0] ia, input logic iwe,
                         input logic [31:0] iw, input logic [31:0] is,
                         input logic dr, input logic [14:0] da, input logic dwe,
                         input logic [31:0] dw, input logic [31:0] ds);
        instr_req_i = ir; instr_addr_i = ia; instr_we_i = iwe; instr_wdata_i = iw; instr_strb_i = is;
        data_req_i  = dr; data_addr_i  = da; data_we_i  = dwe; data_wdata_i  = dw; data_strb_i  = ds;
    endtask

    task automatic idle();
        drive(1'b0, 15'h0, 1'b0, 32'h0, 32'h0, 1'b0, 15'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge, return at rise+1
    task automatic step();
        logic        gi, gd, gwe;
        logic [14:0] ga;
        logic [31:0] gw, gs, ri, rd, nxt_pend;
        int          nxt_owner;
        @(negedge clk_i);
        if (instr_req_i && data_req_i) begin
            gi = m_last_was_data;
            gd = !m_last_was_data;
        end else begin
            gi = instr_req_i;
            gd = data_req_i;
        end
        ga  = gi ? instr_addr_i  : data_addr_i;
        gwe = gi ? instr_we_i    : data_we_i;
        gw  = gi ? instr_wdata_i : data_wdata_i;
        gs  = gi ? instr_strb_i  : data_strb_i;
        ri  = (m_owner == 1) ? m_pend : m_hold_i;
        rd  = (m_owner == 2) ? m_pend : m_hold_d;
        chk("instr_gnt", {31'h0, instr_gnt_o}, {31'h0, gi});
        chk("data_gnt", {31'h0, data_gnt_o}, {31'h0, gd});
        chk("mem_req", {31'h0, mem_req_o}, {31'h0, instr_req_i | data_req_i});
        chk("mem_strb", mem_strb_o, ((gi || gd) && gwe) ? gs : 32'h0);
        if (gi || gd) begin
            chk("mem_addr", {17'h0, mem_addr_o}, {17'h0, ga});
            chk("mem_we", {31'h0, mem_we_o}, {31'h0, gwe});
            if (gwe) chk("mem_wdata", mem_wdata_o, gw);
        end
        chk("instr_rdata", instr_rdata_o, ri);
        chk("data_rdata", data_rdata_o, rd);
        chk("instr_stall", {16'h0, instr_stall_cnt_o}, m_cnt_i);
        chk("data_stall", {16'h0, data_stall_cnt_o}, m_cnt_d);
        last_strb = mem_strb_o;
        last_we   = mem_we_o;
        nxt_owner = ((gi || gd) && !gwe) ? (gi ? 1 : 2) : 0;
        nxt_pend  = bram[ga];
        @(posedge clk_i);
        if (instr_req_i && data_req_i) m_last_was_data = gd;
        if (m_owner == 1) m_hold_i = m_pend;
        if (m_owner == 2) m_hold_d = m_pend;
        m_owner = nxt_owner;
        m_pend  = nxt_pend;
        if (instr_req_i && !gi && m_cnt_i < 65535) m_cnt_i++;
        if (data_req_i && !gd && m_cnt_d < 65535) m_cnt_d++;
        last_gi = gi;
        last_gd = gd;
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) bram[i] = 32'h0;
        bram[16] = 32'hDEADBEEF;
        bram[1]  = 32'h11111111;
        bram[2]  = 32'h22222222;
        bram[3]  = 32'hAAAAAAAA;
        rst_ni = 1'b0;
        idle();
        model_reset();
        #1;
        chk("rst_instr_gnt", {31'h0, instr_gnt_o}, 32'h0);
        chk("rst_data_gnt", {31'h0, data_gnt_o}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_mem_strb", mem_strb_o, 32'h0);
        chk("rst_instr_rdata", instr_rdata_o, 32'h0);
        chk("rst_data_rdata", data_rdata_o, 32'h0);
        chk("rst_stall", {instr_stall_cnt_o, data_stall_cnt_o}, 32'h0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Instruction-only read of 0x0010
        drive(1'b1, 15'h0010, 1'b0, 32'h0, 32'h0, 1'b0, 15'h0, 1'b0, 32'h0, 32'h0);
        step();
        chk("t1_gnt", {31'h0, last_gi}, 32'h1);
        idle();
        chk("t1_rdata_return", instr_rdata_o, 32'hDEADBEEF);
        step();
        step();
        chk("t1_rdata_hold", instr_rdata_o, 32'hDEADBEEF);
        chk("t1_data_rdata", data_rdata_o, 32'h0);

        // Simultaneous reads held for four cycles: grants alternate starting with INSTR
        drive(1'b1, 15'h0001, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0002, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_alt", {31'h0, last_gi}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        idle();
        step();
        step();

        // Partial-strobe write then read-back
        drive(1'b0, 15'h0, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0003, 1'b1, 32'h12345678, 32'h0000FFFF);
        step();
        chk("t3_strb", last_strb, 32'h0000FFFF);
        chk("t3_we", {31'h0, last_we}, 32'h1);
        drive(1'b0, 15'h0, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0003, 1'b0, 32'h0, 32'h0);
        step();
        idle();
        chk("t3_readback", data_rdata_o, 32'hAAAA5678);
        step();

        // Idle stretch: nothing moves
        for (int i = 0; i < 5; i++) step();

        // Randomised traffic; each requester holds its request until granted
        for (int n = 0; n < 400; n++) begin
            if (!(instr_req_i && !last_gi)) begin
                instr_req_i   = ($urandom_range(0, 99) < 70);
                instr_addr_i  = 15'($urandom_range(0, 15));
                instr_we_i    = ($urandom_range(0, 3) == 0);
                instr_wdata_i = $urandom;
                instr_strb_i  = $urandom;
            end
            if (!(data_req_i && !last_gd)) begin
                data_req_i   = ($urandom_range(0, 99) < 70);
                data_addr_i  = 15'($urandom_range(0, 15));
                data_we_i    = ($urandom_range(0, 3) == 0);
                data_wdata_i = $urandom;
                data_strb_i  = $urandom;
            end
            step();
        end
        idle();
        step();

        // Data port starved by pinning the arbitration history so INSTR always wins
        do_reset();
        force dut.last_winner_q = ibex_fpga_mem_pkg::DATA;
        drive(1'b1, 15'h0004, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0005, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 70000; i++) @(posedge clk_i);
        @(negedge clk_i);
        chk("sat_data_stall", {16'h0, data_stall_cnt_o}, {16'h0, ibex_fpga_mem_pkg::StallCntMax});
        chk("sat_instr_stall", {16'h0, instr_stall_cnt_o}, 32'h0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("sat_data_stays", {16'h0, data_stall_cnt_o}, 32'h0000FFFF);
        release dut.last_winner_q;
        @(posedge clk_i);
        #1;
        do_reset();

        // Asynchronous reset in the return cycle of a data read
        drive(1'b0, 15'h0, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0010, 1'b0, 32'h0, 32'h0);
        step();
        idle();
        chk("rst_pre_rdata", data_rdata_o, 32'hDEADBEEF);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_rdata", data_rdata_o, 32'h0);
        chk("rst_async_instr_rdata", instr_rdata_o, 32'h0);
        model_reset();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step();
        chk("rst_no_capture", data_rdata_o, 32'h0);
        drive(1'b1, 15'h0001, 1'b0, 32'h0, 32'h0, 1'b1, 15'h0002, 1'b0, 32'h0, 32'h0);
        step();
        chk("rst_first_conflict_instr", {31'h0, last_gi}, 32'h1);
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
